mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates the single-port program/data memory between three requesters: CPU instruction fetch (IF), load reads (LD) and store writes (ST).
- Issues one memory command per cycle with registered grant and command outputs.
- Tags each read so returned data is steered to its owner one cycle later.
- Applies fixed priority ST > LD > IF, with a starvation boost so fetch cannot be locked out by a load/store burst.
- Sits between the pipelined cpu's memory-side ports and the memory.

Parameters:
ADDR_W, 11, memory address width (matches 11-bit PC/branch/load addresses)
DATA_W, 32, memory word width
STARVE_LIMIT, 4, consecutive denied eligible IF cycles before IF is boosted to top priority (≥1)

Ports:
clk  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request, held until if_gnt seen
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch granted (one-cycle pulse)
if_rvalid  out  1  fetch data valid on if_rdata
if_rdata  out  DATA_W  fetch read data
ld_req  in  1  load read request
ld_addr  in  ADDR_W  load address
ld_gnt  out  1  load granted
ld_rvalid  out  1  load data valid
ld_rdata  out  DATA_W  load read data
st_req  in  1  store write request
st_addr  in  ADDR_W  store address
st_wdata  in  DATA_W  store data
st_gnt  out  1  store granted; the write is committed by the memory at the next edge
flush  in  1  branch taken: cancel in-flight/new fetch
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous-read memory data (valid cycle after mem_en)
if_boost  out  1  starvation boost active (status)

Behaviour:
- Reset (sampled high at an edge):
  - Registered outputs/state cleared: gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, starve counter=0, read owner=NONE.
  - A read in flight at reset produces no rvalid.
- Eligibility at an edge: requester X is eligible if X_req=1 and X_gnt is currently 0 (a registered grant masks its own requester for one cycle). IF is additionally ineligible when flush=1.
- Arbitration order among eligible requesters:
  - if_boost=1 and IF eligible: IF wins.
  - Otherwise ST > LD > IF.
  - Exactly one winner or none.
- Grant/command timing: request sampled at edge E0 → during following cycle C1:
  - winner's X_gnt=1.
  - mem_en=1, mem_addr = winner's address.
  - ST winner: mem_we=1, mem_wdata=st_wdata.
  - Read winner: mem_we=0, mem_wdata holds its previous value.
  - No winner: mem_en=0, mem_we=0, gnt all 0.
- Read return:
  - Read owner (IF/LD/NONE) is registered with the command at E0 and moved to the return stage at E1.
  - During C2, owner's rvalid=1 for exactly one cycle.
  - if_rdata and ld_rdata are both combinationally equal to mem_rdata; only rvalid discriminates.
  - Read latency: request sampled to rvalid = 2 cycles.
- Flush:
  - flush=1 at E1 while the C1 command is an IF read → that read's if_rvalid is suppressed in C2 (the memory access still occurs).
  - flush=1 at E0 → IF not granted that edge.
  - flush has no effect on LD/ST.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) at each edge where IF is eligible but not granted.
  - Clears on IF grant, and on any edge where if_req=0.
  - if_boost = (counter == STARVE_LIMIT), registered.
  - Boost deasserts the cycle after the IF grant.
- Throughput:
  - One access per cycle overall.
  - A given requester at most one grant per 2 cycles.
  - Alternating requesters can fill every cycle.
- Requester rule: address/data held stable while req=1 and gnt not yet seen; may change from the cycle after gnt.

Test Plan:
- Reset: assert reset 2 cycles with all reqs high → all gnt/rvalid/mem_en 0; first grant is st_gnt in the cycle after reset is sampled low.
- Single IF read: if_req, if_addr=0x005 at E0 → C1 if_gnt=1, mem_en=1, mem_we=0, mem_addr=0x005; C2 if_rvalid=1, if_rdata=mem_rdata (e.g. 0xE0A1_0007).
- Simultaneous IF/LD/ST (st_addr=0x010, st_wdata=0xDEADBEEF; ld_addr=0x020): grants in order ST, LD, IF on consecutive cycles; mem_we=1 only in the ST cycle; ld_rvalid the cycle after the LD command.
- Starvation, STARVE_LIMIT=4: LD and ST requests alternate every cycle with if_req held → IF denied 4 eligible cycles, if_boost=1, next grant goes to IF over a pending ST; if_boost=0 the cycle after if_gnt.
- Flush: IF granted at addr 0x00A, flush=1 in the grant cycle → no if_rvalid in the following cycle; a concurrent LD still returns ld_rvalid normally.
- Reset mid-read: LD command issued in C1, reset sampled at E1 → no ld_rvalid in C2; all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between three requesters:
// instruction fetch (IF), load reads (LD) and store writes (ST). One command
// is issued per cycle. Grants and the memory command are registered. Each
// read is tagged with its owner so that the returned word reaches the right
// requester. The word returns in the cycle after the command.
//
// Priority is ST > LD > IF. A saturating starvation counter lifts IF to the
// top priority after STARVE_LIMIT consecutive cycles in which IF was
// eligible but not granted.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   if_req/if_addr -> if_gnt        fetch request and grant pulse
//   if_rvalid/if_rdata              fetch read return
//   ld_req/ld_addr -> ld_gnt        load request and grant pulse
//   ld_rvalid/ld_rdata              load read return
//   st_req/st_addr/st_wdata         store request; st_gnt grant pulse
//   flush                           branch taken: blocks a new fetch grant
//                                   and cancels the return of an issued fetch
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                       memory data, valid the cycle after mem_en
//   if_boost                        starvation boost active
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_gnt,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_boost
);

    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int REQ_IF = 0;
    localparam int REQ_LD = 1;
    localparam int REQ_ST = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    logic [2:0]        req;
    logic [2:0]        elig;
    logic [2:0]        gnt_reg, gnt_next;
    logic              mem_en_reg, mem_en_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              boost_reg, boost_next;
    owner_t            cmd_owner_reg, cmd_owner_next;
    owner_t            ret_owner_reg, ret_owner_next;

    assign req = {st_req, ld_req, if_req};

    // A registered grant masks its own requester for one cycle. This lets
    // the requester see the grant before it is considered again.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_elig
            if (gi == REQ_IF) begin : g_if
                assign elig[gi] = req[gi] & ~gnt_reg[gi] & ~flush;
            end else begin : g_other
                assign elig[gi] = req[gi] & ~gnt_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        gnt_next        = '0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        cmd_owner_next  = OWN_NONE;
        starve_cnt_next = starve_cnt_reg;

        // Winner selection: a boosted, eligible fetch pre-empts everything.
        if (boost_reg && elig[REQ_IF]) begin
            gnt_next[REQ_IF] = 1'b1;
        end else if (elig[REQ_ST]) begin
            gnt_next[REQ_ST] = 1'b1;
        end else if (elig[REQ_LD]) begin
            gnt_next[REQ_LD] = 1'b1;
        end else if (elig[REQ_IF]) begin
            gnt_next[REQ_IF] = 1'b1;
        end

        // A read winner leaves mem_wdata unchanged.
        if (gnt_next[REQ_ST]) begin
            mem_addr_next  = st_addr;
            mem_wdata_next = st_wdata;
        end else if (gnt_next[REQ_LD]) begin
            mem_addr_next  = ld_addr;
            cmd_owner_next = OWN_LD;
        end else if (gnt_next[REQ_IF]) begin
            mem_addr_next  = if_addr;
            cmd_owner_next = OWN_IF;
        end

        mem_en_next = |gnt_next;
        mem_we_next = gnt_next[REQ_ST];

        // The counter runs only while a fetch is continuously wanted. It
        // holds when IF is ineligible for other reasons (flush, own-grant
        // mask).
        if (!if_req || gnt_next[REQ_IF]) begin
            starve_cnt_next = '0;
        end else if (elig[REQ_IF] && (starve_cnt_reg != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
        boost_next = (starve_cnt_next == CNT_W'(STARVE_LIMIT));

        // A flush that arrives while a fetch command is on the bus kills
        // that fetch's return. The memory access itself still happens.
        if ((cmd_owner_reg == OWN_IF) && flush) begin
            ret_owner_next = OWN_NONE;
        end else begin
            ret_owner_next = cmd_owner_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_reg        <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            starve_cnt_reg <= '0;
            boost_reg      <= 1'b0;
            cmd_owner_reg  <= OWN_NONE;
            ret_owner_reg  <= OWN_NONE;
        end else begin
            gnt_reg        <= gnt_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            starve_cnt_reg <= starve_cnt_next;
            boost_reg      <= boost_next;
            cmd_owner_reg  <= cmd_owner_next;
            ret_owner_reg  <= ret_owner_next;
        end
    end

    assign if_gnt    = gnt_reg[REQ_IF];
    assign ld_gnt    = gnt_reg[REQ_LD];
    assign st_gnt    = gnt_reg[REQ_ST];
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_boost  = boost_reg;

    // Both read ports see the memory word directly. Only rvalid says whose
    // word it is.
    assign if_rvalid = (ret_owner_reg == OWN_IF);
    assign ld_rvalid = (ret_owner_reg == OWN_LD);
    assign if_rdata  = mem_rdata;
    assign ld_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// The bench drives the arbiter with directed and random traffic. It also
// models the memory that the arbiter controls.
//
// A reference model samples the same inputs at every rising edge. It applies
// the arbitration rules and pushes the expected outputs for the following
// cycle into a queue. That covers grant, command, boost and read return.
// The model keeps its own shadow copy of memory to predict read data.
//
// A monitor on the falling edge pops one entry per cycle and compares it
// with the outputs of the design.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    // owner codes used by the model
    localparam int O_NONE = 0;
    localparam int O_IF   = 1;
    localparam int O_LD   = 2;
    localparam int O_ST   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, ld_req, st_req, flush;
    logic [ADDR_W-1:0] if_addr, ld_addr, st_addr;
    logic [DATA_W-1:0] st_wdata;
    logic              if_gnt, ld_gnt, st_gnt;
    logic              if_rvalid, ld_rvalid;
    logic [DATA_W-1:0] if_rdata, ld_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_boost;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_gnt   (ld_gnt),
        .ld_rvalid(ld_rvalid),
        .ld_rdata (ld_rdata),
        .st_req   (st_req),
        .st_addr  (st_addr),
        .st_wdata (st_wdata),
        .st_gnt   (st_gnt),
        .flush    (flush),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .if_boost (if_boost)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return 32'hE0A1_0000 ^ (i * 32'h0000_9E37);
    endfunction

    // ---------------- memory attached to the arbiter ----------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // ---------------- reference model + scoreboard queue ----------------
    typedef struct {
        int                cmd;    // O_NONE / O_IF / O_LD / O_ST
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit                rst;
        bit                boost;
        int                rv;     // O_NONE / O_IF / O_LD
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] shadow [0:DEPTH-1];
    int                starve;
    bit                last_gnt_if, last_gnt_ld, last_gnt_st;
    int                pend_owner;
    logic [DATA_W-1:0] pend_data;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        mem_rdata  = '0;
        starve     = 0;
        pend_owner = O_NONE;
        pend_data  = '0;
    end

    always @(posedge clk) begin
        exp_t e;
        bit   e_if, e_ld, e_st;
        e.cmd = O_NONE; e.addr = '0; e.wdata = '0; e.rst = 0;
        e.boost = 0; e.rv = O_NONE; e.rdata = '0;
        if (reset) begin
            // Everything is cleared, including a read already on the bus.
            e.rst       = 1;
            starve      = 0;
            last_gnt_if = 0; last_gnt_ld = 0; last_gnt_st = 0;
            pend_owner  = O_NONE;
        end else begin
            // Return the read issued at the previous edge, unless a flush
            // kills the fetch.
            if (pend_owner == O_LD || (pend_owner == O_IF && !flush)) begin
                e.rv    = pend_owner;
                e.rdata = pend_data;
            end
            pend_owner = O_NONE;

            e_if = if_req && !last_gnt_if && !flush;
            e_ld = ld_req && !last_gnt_ld;
            e_st = st_req && !last_gnt_st;

            if (starve == LIMIT && e_if) e.cmd = O_IF;
            else if (e_st)               e.cmd = O_ST;
            else if (e_ld)               e.cmd = O_LD;
            else if (e_if)               e.cmd = O_IF;

            if (!if_req || e.cmd == O_IF) starve = 0;
            else if (e_if && starve < LIMIT) starve = starve + 1;
            e.boost = (starve == LIMIT);

            last_gnt_if = (e.cmd == O_IF);
            last_gnt_ld = (e.cmd == O_LD);
            last_gnt_st = (e.cmd == O_ST);

            case (e.cmd)
                O_ST: begin
                    e.addr = st_addr; e.wdata = st_wdata;
                    shadow[st_addr] = st_wdata;
                end
                O_LD: begin
                    e.addr = ld_addr;
                    pend_owner = O_LD; pend_data = shadow[ld_addr];
                end
                O_IF: begin
                    e.addr = if_addr;
                    pend_owner = O_IF; pend_data = shadow[if_addr];
                end
                default: ;
            endcase
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt{st,ld,if}", {61'd0, st_gnt, ld_gnt, if_gnt},
                  {61'd0, e.cmd == O_ST, e.cmd == O_LD, e.cmd == O_IF});
            check("mem_en", {63'd0, mem_en}, {63'd0, e.cmd != O_NONE});
            if (e.cmd != O_NONE) begin
                check("mem_we", {63'd0, mem_we}, {63'd0, e.cmd == O_ST});
                check("mem_addr", {53'd0, mem_addr}, {53'd0, e.addr});
                if (e.cmd == O_ST) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
            end
            if (e.rst) begin
                check("reset mem_we", {63'd0, mem_we}, 64'd0);
                check("reset mem_addr", {53'd0, mem_addr}, 64'd0);
                check("reset mem_wdata", {32'd0, mem_wdata}, 64'd0);
            end
            check("if_boost", {63'd0, if_boost}, {63'd0, e.boost});
            check("rvalid{ld,if}", {62'd0, ld_rvalid, if_rvalid},
                  {62'd0, e.rv == O_LD, e.rv == O_IF});
            if (e.rv == O_IF) check("if_rdata", {32'd0, if_rdata}, {32'd0, e.rdata});
            if (e.rv == O_LD) check("ld_rdata", {32'd0, ld_rdata}, {32'd0, e.rdata});
        end
    end

    // ---------------- stimulus ----------------
    // Called on a falling edge. A requester drops its request once it sees
    // its grant. Optional modes keep LD/ST busy, raise random requests, or
    // assert flush in a fetch-grant cycle. Then wait one cycle.
    task automatic drive_cycle(input bit rnd, input bit ldst_busy, input bit flush_on_gnt);
        if (if_gnt) if_req = 1'b0;
        if (ld_gnt) ld_req = 1'b0;
        if (st_gnt) st_req = 1'b0;
        if (ldst_busy) begin
            if (!ld_req) begin ld_req = 1'b1; ld_addr = ADDR_W'($urandom); end
            if (!st_req) begin
                st_req = 1'b1; st_addr = ADDR_W'($urandom); st_wdata = $urandom;
            end
        end
        if (rnd) begin
            if (!if_req && $urandom_range(0, 99) < 60) begin
                if_req = 1'b1; if_addr = ADDR_W'($urandom);
            end
            if (!ld_req && $urandom_range(0, 99) < 40) begin
                ld_req = 1'b1; ld_addr = ADDR_W'($urandom_range(0, 63));
            end
            if (!st_req && $urandom_range(0, 99) < 35) begin
                st_req = 1'b1; st_addr = ADDR_W'($urandom_range(0, 63)); st_wdata = $urandom;
            end
            flush = ($urandom_range(0, 9) == 0);
        end else begin
            flush = flush_on_gnt && if_gnt;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held two cycles with every request active.
        reset  = 1'b1; flush = 1'b0;
        if_req = 1'b1; if_addr = 11'h005;
        ld_req = 1'b1; ld_addr = 11'h020;
        st_req = 1'b1; st_addr = 11'h010; st_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Expect ST, then LD, then IF.
        repeat (6) drive_cycle(0, 0, 0);

        // Single fetch.
        if_req = 1'b1; if_addr = 11'h005;
        repeat (4) drive_cycle(0, 0, 0);

        // Starvation: LD/ST keep the port busy while the fetch waits.
        if_req = 1'b1; if_addr = 11'h0C3;
        repeat (10) drive_cycle(0, 1, 0);
        ld_req = 1'b0; st_req = 1'b0;
        repeat (3) drive_cycle(0, 0, 0);

        // Flush in the fetch-grant cycle, with a concurrent load.
        if_req = 1'b1; if_addr = 11'h00A;
        ld_req = 1'b1; ld_addr = 11'h044;
        repeat (5) drive_cycle(0, 0, 1);

        // Flush while a fetch is requested: no grant that edge.
        if_req = 1'b1; if_addr = 11'h077; flush = 1'b1;
        @(negedge clk);
        repeat (4) drive_cycle(0, 0, 0);

        // Reset lands on the edge that would return a load.
        ld_req = 1'b1; ld_addr = 11'h033;
        drive_cycle(0, 0, 0);
        reset = 1'b1;
        drive_cycle(0, 0, 0);
        reset = 1'b0;
        repeat (3) drive_cycle(0, 0, 0);

        // Random traffic.
        repeat (2000) drive_cycle(1, 0, 0);

        // Drain.
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        repeat (4) drive_cycle(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
